// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency word memory between an
// instruction-fetch port and a load/store data port. Accesses are serialised,
// read data is registered and returned with a one-cycle ready pulse, and a
// streak counter bounds consecutive data grants so fetch cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          streak_q, streak_d;
    logic                is_load_q, is_load_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                err_q, err_d;

    logic                dreq;
    logic                d_grant;

    // Word-address bits outside the memory range and the fetch byte offset
    // are deliberately dropped (wrap-around, silent alignment).
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    assign dreq    = d_rd | d_wr;
    // Data wins unless a fetch is waiting and data has already had its streak.
    assign d_grant = dreq && (!if_req || (streak_q < 4'(MAX_D_STREAK)));

    // Next-state, grant and capture logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        is_load_d   = is_load_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (d_grant) begin
                    state_d     = BUSY_D;
                    cnt_d       = 4'(MEM_LAT);
                    mem_en_d    = 1'b1;
                    // Simultaneous rd+wr is resolved as a store.
                    mem_we_d    = d_wr;
                    is_load_d   = !d_wr;
                    mem_addr_d  = d_addr[ADDR_W+1:2];
                    mem_wdata_d = d_wdata;
                    if (if_req) begin
                        streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                    if ((d_rd && d_wr) || (d_addr[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end
                end else if (if_req) begin
                    state_d     = BUSY_I;
                    cnt_d       = 4'(MEM_LAT);
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    is_load_d   = 1'b0;
                    mem_addr_d  = if_addr[ADDR_W+1:2];
                    mem_wdata_d = 32'd0;
                    streak_d    = 4'd0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Counter reaches zero in the cycle mem_rdata is valid.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        if (is_load_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Requesters update after ready, so no arbitration here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            streak_q    <= 4'd0;
            is_load_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            is_load_q   <= is_load_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency word memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Serialises accesses, returns registered read data with a one-cycle ready pulse, and prevents fetch starvation by bounding consecutive data grants.
- Sits between mips_cpu_top's IF/MEM stages and a unified memory. Requesters stall while their request is pending without ready.

Parameters:
- ADDR_W, 8, memory word-address width; mem_addr = byte_addr[ADDR_W+1:2].
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (or write commit); legal range 1..15.
- MAX_D_STREAK, 4, maximum consecutive data grants while if_req is pending; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_rd  in  1  load request, held until d_ready
- d_wr  in  1  store request, held until d_ready
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for load/store
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write qualifier, valid with mem_en
- mem_addr  out  ADDR_W  word address, valid with mem_en
- mem_wdata  out  32  write data, valid with mem_en
- mem_rdata  in  32  read data, valid exactly MEM_LAT cycles after mem_en
- err  out  1  sticky protocol-error flag

Behaviour:
- All outputs are registered.
- Reset sets state to IDLE, the latency counter and d_streak to 0, and every output to 0 (including if_rdata, d_rdata and err).
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE arbitration, sampled at the clock edge. dreq = d_rd|d_wr.
  - Data grant when dreq and (!if_req or d_streak < MAX_D_STREAK).
  - Otherwise, instruction grant when if_req.
  - Otherwise, stay in IDLE.
- Grant effects: in the next cycle, mem_en=1 for exactly one cycle, with mem_addr/mem_we/mem_wdata latched from the granted port. Fetches always use mem_we=0. The state goes to BUSY_I or BUSY_D and the latency counter loads MEM_LAT.
- BUSY state:
  - The counter decrements each cycle.
  - In the cycle where mem_rdata is valid (MEM_LAT cycles after mem_en), the arbiter captures it into if_rdata or d_rdata (loads only) and transitions to DONE.
  - d_rdata is left unchanged on stores.
- DONE: the selected ready output is 1 for this cycle only. No arbitration happens in DONE. Next state is IDLE.
- Requesters drop or update their request in the cycle after ready. A request still high in DONE is therefore not reissued.
- Latency: request first seen in cycle 0 -> mem_en in cycle 1 -> ready in cycle 2+MEM_LAT. Minimum spacing between grants is 3+MEM_LAT cycles.
- d_streak updates on each data grant:
  - Increments (saturating at 15) if if_req=1 at the grant; otherwise clears to 0.
  - Clears to 0 on every instruction grant.
- d_rd and d_wr both high at a data grant: the access is treated as a store, and err is set.
- d_addr[1:0] != 0 at a data grant: the low bits are ignored, and err is set.
- Fetch address low bits are ignored silently.
- err is sticky until reset.
- Request inputs are ignored except in IDLE. Changes during BUSY/DONE have no effect on the in-flight access.
- Reset asserted mid-access: the arbiter aborts to IDLE on that edge, and no ready pulse is produced. Any late mem_rdata is ignored.
- Address above the ADDR_W range is truncated (wrap-around); no error.

Test Plan:
- Single fetch, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=0x4 in cycle 0; memory word 1 = 0x20030007.
  - Response: mem_en=1, mem_addr=1, mem_we=0 in cycle 1; if_ready=1 with if_rdata=0x20030007 in cycle 3, and if_ready=0 in cycle 4.
- Store then load, MEM_LAT=2:
  - Stimulus: d_wr with d_addr=0x8, d_wdata=0x9, then d_rd with d_addr=0x8.
  - Response: mem_we=1 with mem_addr=2; d_ready 4 cycles after the request; the load returns d_rdata=0x9; err stays 0.
- Contention, MAX_D_STREAK=2:
  - Stimulus: if_req and d_rd held continuously.
  - Response: grant order D, D, I, D, D, I; d_streak returns to 0 after each I grant.
- Protocol errors:
  - Stimulus: d_rd=d_wr=1 with d_addr=0x6.
  - Response: mem_we=1, mem_addr=1, err=1 and stays set through later clean accesses until reset.
- Reset mid-access:
  - Stimulus: assert reset the cycle after mem_en.
  - Response: no if_ready/d_ready pulse; all outputs 0 the next cycle; a new request after reset completes with normal latency.
- Idle hold:
  - Stimulus: no requests for 20 cycles.
  - Response: mem_en, if_ready and d_ready remain 0; state stays IDLE.
